// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - interrupt lines, core handshake and config bus of irq_arbiter
interface irq_arbiter_if #(
    parameter int NUM_IRQ = 3
);
    logic [NUM_IRQ-1:0] irq_n;
    logic [NUM_IRQ-1:0] cpu_irq;
    logic [NUM_IRQ-1:0] cpu_eoi;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [7:0]         cfg_rdata;
    logic               busy;

    // Side that drives the interrupt lines, the eoi pulses and the config bus
    modport master (
        output irq_n,
        output cpu_eoi,
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cpu_irq,
        input  cfg_rdata,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  irq_n,
        input  cpu_eoi,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cpu_irq,
        output cfg_rdata,
        output busy
    );
endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - synchronizing, lowest-index-first interrupt arbiter with holdoff and timeout
module irq_arbiter #(
    parameter int NUM_IRQ     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic         clk_50m,
    input  logic         reset,
    irq_arbiter_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT + 2);
    localparam int HW = $clog2(HOLDOFF + 2);
    localparam logic [GW-1:0] GRANT_LAST = GW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    // Synchronizer chain: element 0 is the newest sample, SYNC_STAGES-1 the settled one
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] fall;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] cpu_irq_q, cpu_irq_d;
    logic [2:0]         grant_idx_q, grant_idx_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;

    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] ovr_q, ovr_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [NUM_IRQ-1:0] req;
    logic [2:0]         win_idx;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic               to_set;
    logic               w_mask, w_pend, w_ovr, w_stat;
    logic [NUM_IRQ-1:0] wbits;
    logic               unused_wdata;

    assign unused_wdata = ^bus.cfg_wdata;

    // Shift the raw lines through the synchronizer and flag settled 1->0 transitions
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.irq_n};
        prev_d = sync_q[SYNC_STAGES-1];
        fall   = prev_q & ~sync_q[SYNC_STAGES-1];
    end

    // Lowest unmasked pending index wins arbitration
    always_comb begin
        req     = pend_q & ~mask_q;
        win_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // Next state of the grant FSM, its registered cpu_irq and the grant/holdoff counters
    always_comb begin
        state_d     = state_q;
        cpu_irq_d   = cpu_irq_q;
        grant_idx_d = grant_idx_q;
        gcnt_d      = gcnt_q;
        hcnt_d      = hcnt_q;
        eoi_clr     = '0;
        to_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d     = S_GRANT;
                    cpu_irq_d   = NUM_IRQ'(1) << win_idx;
                    grant_idx_d = win_idx;
                    gcnt_d      = '0;
                end
            end
            S_GRANT: begin
                if (|(bus.cpu_eoi & cpu_irq_q) || (gcnt_q >= GRANT_LAST)) begin
                    state_d     = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                    cpu_irq_d   = '0;
                    grant_idx_d = '0;
                    hcnt_d      = '0;
                    if (|(bus.cpu_eoi & cpu_irq_q)) begin
                        eoi_clr = cpu_irq_q;
                    end else begin
                        to_set = 1'b1;
                    end
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            S_HOLDOFF: begin
                if (hcnt_q >= HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                cpu_irq_d = '0;
            end
        endcase
    end

    // Register file updates; a set event always beats a same-cycle clear
    always_comb begin
        w_mask    = bus.cfg_we && (bus.cfg_addr == 2'd0);
        w_pend    = bus.cfg_we && (bus.cfg_addr == 2'd1);
        w_ovr     = bus.cfg_we && (bus.cfg_addr == 2'd2);
        w_stat    = bus.cfg_we && (bus.cfg_addr == 2'd3);
        wbits     = bus.cfg_wdata[NUM_IRQ-1:0];
        mask_d    = w_mask ? wbits : mask_q;
        pend_d    = (pend_q & ~((w_pend ? wbits : '0) | eoi_clr)) | fall;
        ovr_d     = (ovr_q & ~(w_ovr ? wbits : '0)) | (fall & pend_q);
        timeout_d = (timeout_q & ~(w_stat & bus.cfg_wdata[7])) | to_set;
        rdata_d   = 8'h00;
        case (bus.cfg_addr)
            2'd0: rdata_d = 8'(mask_q);
            2'd1: rdata_d = 8'(pend_q);
            2'd2: rdata_d = 8'(ovr_q);
            2'd3: rdata_d = {timeout_q, 3'b000, (state_q == S_GRANT), grant_idx_q};
            default: rdata_d = 8'h00;
        endcase
    end

    // All state; reset forces idle lines, an empty register file and drops cpu_irq at once
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            prev_q      <= '1;
            state_q     <= S_IDLE;
            cpu_irq_q   <= '0;
            grant_idx_q <= '0;
            gcnt_q      <= '0;
            hcnt_q      <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            timeout_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cpu_irq_q   <= cpu_irq_d;
            grant_idx_q <= grant_idx_d;
            gcnt_q      <= gcnt_d;
            hcnt_q      <= hcnt_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            timeout_q   <= timeout_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.cpu_irq   = cpu_irq_q;
    assign bus.cfg_rdata = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed self-checking bench for irq_arbiter
module tb_irq_arbiter;
    localparam int N = 3;

    logic clk_50m = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] d;

    irq_arbiter_if #(.NUM_IRQ(N)) bus ();

    irq_arbiter #(
        .NUM_IRQ    (N),
        .SYNC_STAGES(2),
        .HOLDOFF    (4),
        .TIMEOUT    (1024)
    ) dut (
        .clk_50m(clk_50m),
        .reset  (reset),
        .bus    (bus)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick(1);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [7:0] data);
        bus.cfg_addr = addr;
        tick(1);
        data = bus.cfg_rdata;
    endtask

    task automatic eoi(input logic [N-1:0] bits);
        bus.cpu_eoi = bits;
        tick(1);
        bus.cpu_eoi = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.irq_n     = '1;
        bus.cpu_eoi   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 8'h00;
        tick(2);
        check("rst_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdata", 32'(bus.cfg_rdata), 32'd0);
        reset = 1'b0;
        tick(5);
        check("rst_no_edge", 32'(bus.busy), 32'd0);

        // single line: exact latency, ignored foreign eoi, release and holdoff length
        bus.cfg_addr = 2'd1;
        bus.irq_n    = 3'b101;
        tick(3);
        check("t1_irq_early", 32'(bus.cpu_irq), 32'd0);
        check("t1_busy_early", 32'(bus.busy), 32'd0);
        tick(1);
        check("t1_grant", 32'(bus.cpu_irq), 32'h2);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_pending", 32'(bus.cfg_rdata), 32'h02);
        bus.irq_n = 3'b111;
        eoi(3'b101);
        check("t1_eoi_ignored", 32'(bus.cpu_irq), 32'h2);
        eoi(3'b010);
        check("t1_release", 32'(bus.cpu_irq), 32'd0);
        check("t1_busy_hold", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_pending_clr", 32'(bus.cfg_rdata), 32'd0);
        tick(2);
        check("t1_holdoff", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_idle", 32'(bus.busy), 32'd0);
        eoi(3'b111);
        check("t1_stray_eoi", 32'(bus.busy), 32'd0);

        // simultaneous edges on 0 and 2: priority order with holdoff gap
        bus.irq_n = 3'b010;
        tick(4);
        check("t2_first", 32'(bus.cpu_irq), 32'h1);
        bus.irq_n = 3'b111;
        eoi(3'b001);
        check("t2_release", 32'(bus.cpu_irq), 32'd0);
        tick(4);
        check("t2_holdoff_gap", 32'(bus.cpu_irq), 32'd0);
        tick(1);
        check("t2_second", 32'(bus.cpu_irq), 32'h4);
        eoi(3'b100);
        wait_idle("t2_idle");

        // masking holds off arbitration; bits above NUM_IRQ are dropped
        wr(2'd0, 8'hF9);
        rd(2'd0, d);
        check("t3_mask_rb", 32'(d), 32'h01);
        bus.irq_n = 3'b110;
        tick(6);
        check("t3_masked_irq", 32'(bus.cpu_irq), 32'd0);
        check("t3_masked_busy", 32'(bus.busy), 32'd0);
        bus.irq_n = 3'b111;
        rd(2'd1, d);
        check("t3_pending", 32'(d), 32'h01);
        wr(2'd0, 8'h00);
        check("t3_unmask_lat", 32'(bus.cpu_irq), 32'd0);
        tick(1);
        check("t3_unmasked", 32'(bus.cpu_irq), 32'h1);
        eoi(3'b001);
        wait_idle("t3_idle");

        // timeout: 1024 grant cycles, sticky flag, pending kept, regrant after holdoff
        bus.irq_n = 3'b011;
        tick(4);
        check("t4_grant", 32'(bus.cpu_irq), 32'h4);
        bus.irq_n    = 3'b111;
        bus.cfg_addr = 2'd3;
        tick(1);
        check("t4_status_grant", 32'(bus.cfg_rdata), 32'h0A);
        tick(1022);
        check("t4_before_timeout", 32'(bus.cpu_irq), 32'h4);
        tick(1);
        check("t4_timeout_drop", 32'(bus.cpu_irq), 32'd0);
        tick(1);
        check("t4_status_timeout", 32'(bus.cfg_rdata), 32'h80);
        bus.cfg_addr = 2'd1;
        tick(1);
        check("t4_pending_kept", 32'(bus.cfg_rdata), 32'h04);
        tick(2);
        check("t4_holdoff_gap", 32'(bus.cpu_irq), 32'd0);
        tick(1);
        check("t4_regrant", 32'(bus.cpu_irq), 32'h4);
        bus.cfg_addr = 2'd3;
        tick(1);
        check("t4_status_regrant", 32'(bus.cfg_rdata), 32'h8A);
        eoi(3'b100);
        check("t4_release", 32'(bus.cpu_irq), 32'd0);
        wait_idle("t4_idle");
        wr(2'd3, 8'h80);
        rd(2'd3, d);
        check("t4_timeout_clr", 32'(d), 32'h00);

        // overrun, set-beats-clear, and grant immune to mask and pending W1C
        bus.irq_n = 3'b101;
        tick(4);
        check("t5_grant", 32'(bus.cpu_irq), 32'h2);
        bus.irq_n = 3'b111;
        tick(4);
        bus.irq_n = 3'b101;
        tick(4);
        rd(2'd2, d);
        check("t5_overrun", 32'(d), 32'h02);
        bus.irq_n = 3'b111;
        tick(4);
        bus.irq_n = 3'b101;
        tick(2);
        wr(2'd2, 8'h02);
        rd(2'd2, d);
        check("t5_overrun_set_wins", 32'(d), 32'h02);
        bus.irq_n = 3'b111;
        wr(2'd2, 8'h02);
        rd(2'd2, d);
        check("t5_overrun_w1c", 32'(d), 32'h00);
        wr(2'd0, 8'h02);
        check("t5_mask_no_revoke", 32'(bus.cpu_irq), 32'h2);
        wr(2'd1, 8'h02);
        rd(2'd1, d);
        check("t5_pending_w1c", 32'(d), 32'h00);
        check("t5_w1c_no_revoke", 32'(bus.cpu_irq), 32'h2);
        wr(2'd0, 8'h00);
        eoi(3'b010);
        check("t5_release", 32'(bus.cpu_irq), 32'd0);
        wait_idle("t5_idle");

        // reset in the middle of a grant acts without a clock edge
        wr(2'd0, 8'h04);
        bus.irq_n = 3'b110;
        tick(4);
        check("t6_grant", 32'(bus.cpu_irq), 32'h1);
        bus.irq_n = 3'b111;
        #3 reset = 1'b1;
        #2;
        check("t6_async_irq", 32'(bus.cpu_irq), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        check("t6_async_rdata", 32'(bus.cfg_rdata), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(4);
        check("t6_no_regrant", 32'(bus.busy), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("t6_reg%0d", a), 32'(d), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter NUM_IRQ, default 3, number of interrupt lines (1..7).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per input line (>=2).
REQ-003 Parameter HOLDOFF, default 4, idle cycles after each grant before the next arbitration.
REQ-004 Parameter TIMEOUT, default 1024, grant cycles allowed before forced release.
REQ-005 clk_50m  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 irq_n  input  NUM_IRQ  raw asynchronous interrupt lines, active-low, idle high.
REQ-008 cpu_irq  output  NUM_IRQ  one-hot interrupt request to the core.
REQ-009 cpu_eoi  input  NUM_IRQ  end-of-interrupt pulses from the core.
REQ-010 cfg_we  input  1  config write strobe, one cycle.
REQ-011 cfg_addr  input  2  config register select.
REQ-012 cfg_wdata  input  8  config write data.
REQ-013 cfg_rdata  output  8  config read data, registered.
REQ-014 busy  output  1  high while state is not IDLE.

Function
REQ-015 Each irq_n bit SHALL pass through SYNC_STAGES flops; a synchronized 1->0 transition SHALL set the matching PENDING bit on the following cycle.
REQ-016 A new falling edge on a line whose PENDING bit is already set SHALL set the matching OVERRUN bit; PENDING stays 1.
REQ-017 Register map: addr0 MASK (RW, 1=masked), addr1 PENDING (read; write-1-to-clear), addr2 OVERRUN (read; W1C), addr3 STATUS (read: bit7 TIMEOUT sticky, bits2:0 granted index, bit3 grant valid; write bit7=1 clears TIMEOUT).
REQ-018 Register bits at or above NUM_IRQ SHALL read 0 and ignore writes.
REQ-019 cfg_rdata SHALL present the addressed register one cycle after cfg_addr is sampled, regardless of cfg_we.
REQ-020 A set event and a W1C clear of the same PENDING or OVERRUN bit in the same cycle: set wins.
REQ-021 State machine: IDLE, GRANT, HOLDOFF.
REQ-022 IDLE -> GRANT when (PENDING & ~MASK) != 0; winner = lowest index (bit 0 highest priority); cpu_irq asserts the winner bit on the cycle after the transition decision.
REQ-023 In GRANT, cpu_irq SHALL hold exactly the winner bit, stable, until release.
REQ-024 GRANT -> HOLDOFF on cpu_eoi bit matching the winner: cpu_irq deasserts next cycle; winner's PENDING clears in the same edge.
REQ-025 cpu_eoi bits not matching the winner, or arriving outside GRANT, SHALL be ignored.
REQ-026 GRANT -> HOLDOFF after TIMEOUT cycles without matching eoi: cpu_irq deasserts, PENDING stays set, STATUS TIMEOUT sets.
REQ-027 Masking the winner during GRANT SHALL NOT revoke the grant; mask applies only at arbitration.
REQ-028 W1C of the winner's PENDING during GRANT SHALL NOT revoke the grant; a later eoi still releases normally.
REQ-029 HOLDOFF -> IDLE after exactly HOLDOFF cycles; cpu_irq SHALL be all-zero in HOLDOFF and IDLE.
REQ-030 Edges arriving in any state SHALL be captured; no edge is lost except as recorded by OVERRUN.
REQ-031 Grant and timeout counters SHALL saturate and not wrap.

Reset
REQ-032 On reset: state IDLE, cpu_irq=0, busy=0, cfg_rdata=0, MASK=0, PENDING=0, OVERRUN=0, TIMEOUT=0, counters=0, synchronizer flops=1 (idle).
REQ-033 Reset asserted mid-GRANT SHALL drop cpu_irq immediately (asynchronously) and discard pending state.
REQ-034 No edge SHALL be detected from the reset-release value of the synchronizers alone.

Verification
REQ-035 irq_n[1] high->low, MASK=0 -> PENDING=3'b010 after SYNC_STAGES+1 cycles, cpu_irq=3'b010 one cycle later, busy=1; cpu_eoi=3'b010 pulse -> cpu_irq=0 next cycle, PENDING=0, IDLE after 4 HOLDOFF cycles.
REQ-036 irq_n[0] and irq_n[2] fall same cycle -> cpu_irq=3'b001 first; after eoi and HOLDOFF, cpu_irq=3'b100.
REQ-037 MASK=3'b001, irq_n[0] falls -> PENDING=3'b001, cpu_irq stays 0; write MASK=0 -> cpu_irq=3'b001.
REQ-038 Grant on bit 2, no eoi -> cpu_irq drops after 1024 cycles, STATUS=8'h80 ORed grant fields cleared, PENDING[2]=1, regrant after HOLDOFF.
REQ-039 Second falling edge on irq_n[1] while PENDING[1]=1 -> OVERRUN=3'b010; W1C write addr2 data 8'h02 same cycle as a third edge -> OVERRUN stays 3'b010.
REQ-040 reset pulsed during GRANT -> cpu_irq=0 and busy=0 without waiting for a clock edge; all registers read 0.
